// File: rtl/rv32_pkg.sv
// Shared RV32 write-back types: load encodings, load tracking entry, load formatting helpers.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_funct3_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } ld_entry_t;

  // Misaligned halfwords fall back to the even half; unknown funct3 passes the raw word.
  function automatic logic [XLEN-1:0] ld_format(input ld_entry_t e, input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{e.off, 3'b000} +: 8];
    h = w[{e.off[1], 4'b0000} +: 16];
    case (e.funct3)
      LB:      return {{(XLEN-8){b[7]}}, b};
      LBU:     return {{(XLEN-8){1'b0}}, b};
      LH:      return {{(XLEN-16){h[15]}}, h};
      LHU:     return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic ld_fmt_err(input ld_entry_t e);
    case (e.funct3)
      LB, LBU:  return 1'b0;
      LH, LHU:  return e.off[0];
      LW:       return e.off != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Circular buffer of outstanding loads; push/pop take effect at the clock edge, head is combinational.
// Caller gates push on !full and pop on !empty; per-slot valid/rd feed the hazard scoreboard.
module wb_load_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  ld_entry_t          i_push_dat,
  input  logic               i_pop,
  output ld_entry_t          o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [DEPTH-1:0]   o_ent_vld,
  output logic [DEPTH*5-1:0] o_ent_rd
);

  localparam int AW = $clog2(DEPTH);

  ld_entry_t        r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [DEPTH-1:0] r_vld;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head    = r_mem[r_rptr[AW-1:0]];
  assign o_ent_vld = r_vld;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    assign o_ent_rd[g*5 +: 5] = r_mem[g].rd;
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
  end

  // Push and pop never touch the same slot: push is blocked when full, pop when empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_vld  <= '0;
    end else begin
      if (i_push) begin
        r_wptr                <= r_wptr + 1'b1;
        r_vld[r_wptr[AW-1:0]] <= 1'b1;
      end
      if (i_pop) begin
        r_rptr                <= r_rptr + 1'b1;
        r_vld[r_rptr[AW-1:0]] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write driver: one registered write per cycle, 1-cycle latency; load responses beat ALU.
// ALU is held off on a load response or a pending load to the same rd; loads stall on a full tracker.
module regfile_writeback
  import rv32_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  output logic            o_alu_ready,
  input  logic            i_ld_issue,
  input  logic [4:0]      i_ld_rd,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_off,
  output logic            o_ld_ready,
  input  logic            i_ld_resp,
  input  logic [XLEN-1:0] i_ld_rdata,
  input  logic [4:0]      i_q_rs1,
  input  logic [4:0]      i_q_rs2,
  output logic            o_busy_rs1,
  output logic            o_busy_rs2,
  output logic [4:0]      o_waddr,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_write,
  output logic            o_err
);

  ld_entry_t               w_head;
  ld_entry_t               w_push_dat;
  logic                    w_full;
  logic                    w_empty;
  logic [LD_DEPTH-1:0]     w_ent_vld;
  logic [LD_DEPTH*5-1:0]   w_ent_rd;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_alu_acc;
  logic                    w_busy_alu;

  logic                    r_write;
  logic [4:0]              r_waddr;
  logic [XLEN-1:0]         r_wdata;
  logic                    r_err;

  // An entry being popped this cycle still reads busy, which keeps WAW order with the load write.
  function automatic logic rd_busy(input logic [4:0] r, input logic [LD_DEPTH-1:0] vld,
                                   input logic [LD_DEPTH*5-1:0] rds);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (vld[i] && (rds[i*5 +: 5] == r)) hit = 1'b1;
    end
    return hit && (r != 5'd0);
  endfunction

  assign w_push_dat = '{rd: i_ld_rd, funct3: i_ld_funct3, off: i_ld_off};
  assign w_push     = i_ld_issue && !w_full;
  assign w_pop      = i_ld_resp && !w_empty;
  assign w_busy_alu = rd_busy(i_alu_rd, w_ent_vld, w_ent_rd);
  assign o_alu_ready = i_alu_valid ? (!i_ld_resp && !w_busy_alu) : 1'b1;
  assign w_alu_acc  = i_alu_valid && o_alu_ready;
  assign o_ld_ready = !w_full;
  assign o_busy_rs1 = rd_busy(i_q_rs1, w_ent_vld, w_ent_rd);
  assign o_busy_rs2 = rd_busy(i_q_rs2, w_ent_vld, w_ent_rd);

  wb_load_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_ent_vld  (w_ent_vld),
    .o_ent_rd   (w_ent_rd)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_write <= (w_head.rd != 5'd0);
        r_waddr <= w_head.rd;
        r_wdata <= ld_format(w_head, i_ld_rdata);
      end else if (w_alu_acc) begin
        r_write <= (i_alu_rd != 5'd0);
        r_waddr <= i_alu_rd;
        r_wdata <= i_alu_data;
      end else begin
        r_write <= 1'b0;
      end
      if ((i_ld_issue && w_full) || (i_ld_resp && w_empty) || (w_pop && ld_fmt_err(w_head)))
        r_err <= 1'b1;
    end
  end

  assign o_write = r_write;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;
  assign o_err   = r_err;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vector table, hand sequences for errors/reset, random vs queue model.
module tb_regfile_writeback;
  import rv32_pkg::*;

  localparam int LD_DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_ld_issue;
  logic [4:0]  i_ld_rd;
  logic [2:0]  i_ld_funct3;
  logic [1:0]  i_ld_off;
  logic        o_ld_ready;
  logic        i_ld_resp;
  logic [31:0] i_ld_rdata;
  logic [4:0]  i_q_rs1;
  logic [4:0]  i_q_rs2;
  logic        o_busy_rs1;
  logic        o_busy_rs2;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        o_write;
  logic        o_err;

  always #5 clk = ~clk;

  regfile_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data), .o_alu_ready(o_alu_ready),
    .i_ld_issue(i_ld_issue), .i_ld_rd(i_ld_rd), .i_ld_funct3(i_ld_funct3), .i_ld_off(i_ld_off),
    .o_ld_ready(o_ld_ready), .i_ld_resp(i_ld_resp), .i_ld_rdata(i_ld_rdata),
    .i_q_rs1(i_q_rs1), .i_q_rs2(i_q_rs2), .o_busy_rs1(o_busy_rs1), .o_busy_rs2(o_busy_rs2),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_write(o_write), .o_err(o_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic li; logic [4:0] lrd; logic [2:0] f3; logic [1:0] off;
    logic rsp; logic [31:0] rdat; logic [4:0] q1;
    logic e_ar; logic e_lr; logic e_b1;
    logic e_w; logic [4:0] e_wa; logic [31:0] e_wd; logic e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic li, input logic [4:0] lrd, input logic [2:0] f3, input logic [1:0] off,
                     input logic rsp, input logic [31:0] rdat, input logic [4:0] q1,
                     input logic e_ar, input logic e_lr, input logic e_b1,
                     input logic e_w, input logic [4:0] e_wa, input logic [31:0] e_wd, input logic e_err);
    vec_t v;
    v = '{av, ard, adat, li, lrd, f3, off, rsp, rdat, q1, e_ar, e_lr, e_b1, e_w, e_wa, e_wd, e_err};
    tbl.push_back(v);
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic li, input logic [4:0] lrd, input logic [2:0] f3, input logic [1:0] off,
                        input logic rsp, input logic [31:0] rdat);
    i_alu_valid = av; i_alu_rd = ard; i_alu_data = adat;
    i_ld_issue = li; i_ld_rd = lrd; i_ld_funct3 = f3; i_ld_off = off;
    i_ld_resp = rsp; i_ld_rdata = rdat;
  endtask

  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic li, input logic [4:0] lrd, input logic [2:0] f3, input logic [1:0] off,
                      input logic rsp, input logic [31:0] rdat);
    set_in(av, ard, adat, li, lrd, f3, off, rsp, rdat);
    @(posedge clk); #1;
  endtask

  // Reference model: a queue of outstanding loads plus the expected write-port registers.
  typedef struct { logic [4:0] rd; logic [2:0] f3; logic [1:0] off; } m_ent_t;
  m_ent_t      mq[$];
  logic        m_write;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_err;

  function automatic logic m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic m_legal(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) == 0;
    if (f3 == 3'd2) return off == 0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_write = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_err = 1'b0;
  endtask

  task automatic rnd_cycle();
    logic   full, ar;
    m_ent_t e;
    @(negedge clk);
    full = (mq.size() == LD_DEPTH);
    ar   = i_alu_valid ? (!i_ld_resp && !m_busy(i_alu_rd)) : 1'b1;
    chk("rnd_alu_ready", o_alu_ready, ar);
    chk("rnd_ld_ready", o_ld_ready, !full);
    chk("rnd_busy_rs1", o_busy_rs1, m_busy(i_q_rs1));
    chk("rnd_busy_rs2", o_busy_rs2, m_busy(i_q_rs2));
    if (i_ld_resp && mq.size() == 0) m_err = 1'b1;
    if (i_ld_issue && full) m_err = 1'b1;
    if (i_ld_resp && mq.size() != 0) begin
      e = mq.pop_front();
      m_write = (e.rd != 0); m_waddr = e.rd; m_wdata = m_fmt(e.f3, e.off, i_ld_rdata);
      if (!m_legal(e.f3, e.off)) m_err = 1'b1;
    end else if (i_alu_valid && ar) begin
      m_write = (i_alu_rd != 0); m_waddr = i_alu_rd; m_wdata = i_alu_data;
    end else begin
      m_write = 1'b0;
    end
    if (i_ld_issue && !full) begin
      e.rd = i_ld_rd; e.f3 = i_ld_funct3; e.off = i_ld_off;
      mq.push_back(e);
    end
    @(posedge clk); #1;
    chk("rnd_write", o_write, m_write);
    if (m_write) begin
      chk("rnd_waddr", o_waddr, m_waddr);
      chk("rnd_wdata", o_wdata, m_wdata);
    end
    chk("rnd_err", o_err, m_err);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    @(negedge clk) i_rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0;
    i_q_rs1 = 5'd1; i_q_rs2 = 5'd0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_write", o_write, 0);
    chk("rst_waddr", o_waddr, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ld_ready", o_ld_ready, 1);
    chk("rst_busy_rs1", o_busy_rs1, 0);
    @(negedge clk) i_rst_n = 1'b1;
    @(posedge clk); #1;

    // av ard adat | li lrd f3 off | rsp rdat | q1 | e_ar e_lr e_b1 | e_w e_wa e_wd e_err
    add(1, 5, 'h1234,     0, 0, 0, 0, 0, 0,            0, 1, 1, 0, 1, 5, 'h1234, 0);
    add(1, 0, 'h55,       0, 0, 0, 0, 0, 0,            0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,          1, 7, 3'b000, 3, 0, 0,       7, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,          0, 0, 0, 0, 1, 'h80FF0000,   7, 1, 1, 1, 1, 7, 'hFFFFFF80, 0);
    add(0, 0, 0,          0, 0, 0, 0, 0, 0,            7, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,          1, 8, 3'b101, 2, 0, 0,       8, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,          0, 0, 0, 0, 1, 'h80010000,   8, 1, 1, 1, 1, 8, 'h00008001, 0);
    add(0, 0, 0,          1, 4, 3'b010, 0, 0, 0,       0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 3, 'h33,       0, 0, 0, 0, 1, 'hDEADBEEF,   0, 0, 1, 0, 1, 4, 'hDEADBEEF, 0);
    add(1, 3, 'h33,       0, 0, 0, 0, 0, 0,            0, 1, 1, 0, 1, 3, 'h33, 0);
    add(0, 0, 0,          1, 9, 3'b010, 0, 0, 0,       9, 1, 1, 0, 0, 0, 0, 0);
    add(1, 9, 'h99,       0, 0, 0, 0, 0, 0,            9, 0, 1, 1, 0, 0, 0, 0);
    add(1, 9, 'h99,       0, 0, 0, 0, 1, 'h12345678,   9, 0, 1, 1, 1, 9, 'h12345678, 0);
    add(1, 9, 'h99,       0, 0, 0, 0, 0, 0,            9, 1, 1, 0, 1, 9, 'h99, 0);
    add(0, 0, 0,          1, 10, 3'b010, 0, 0, 0,     10, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,          1, 11, 3'b010, 0, 0, 0,     10, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 12, 3'b010, 0, 0, 0,     10, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 13, 3'b010, 0, 0, 0,     10, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 14, 3'b010, 0, 0, 0,     10, 1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0,          0, 0, 0, 0, 1, 'hA0,        10, 1, 0, 1, 1, 10, 'hA0, 1);
    add(0, 0, 0,          0, 0, 0, 0, 1, 'hA1,        10, 1, 1, 0, 1, 11, 'hA1, 1);
    add(0, 0, 0,          0, 0, 0, 0, 1, 'hA2,        10, 1, 1, 0, 1, 12, 'hA2, 1);
    add(0, 0, 0,          0, 0, 0, 0, 1, 'hA3,        10, 1, 1, 0, 1, 13, 'hA3, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].li, tbl[i].lrd, tbl[i].f3, tbl[i].off,
             tbl[i].rsp, tbl[i].rdat);
      i_q_rs1 = tbl[i].q1;
      @(negedge clk);
      chk($sformatf("v%0d_alu_ready", i), o_alu_ready, tbl[i].e_ar);
      chk($sformatf("v%0d_ld_ready", i), o_ld_ready, tbl[i].e_lr);
      chk($sformatf("v%0d_busy_rs1", i), o_busy_rs1, tbl[i].e_b1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_write", i), o_write, tbl[i].e_w);
      if (tbl[i].e_w) begin
        chk($sformatf("v%0d_waddr", i), o_waddr, tbl[i].e_wa);
        chk($sformatf("v%0d_wdata", i), o_wdata, tbl[i].e_wd);
      end
      chk($sformatf("v%0d_err", i), o_err, tbl[i].e_err);
    end
    i_q_rs1 = 5'd0;

    // Misaligned halfword: written as if even-aligned, flags error.
    do_reset();
    chk("mis_err_pre", o_err, 0);
    step(0, 0, 0, 1, 6, 3'b001, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 'h00008123);
    chk("mis_write", o_write, 1);
    chk("mis_waddr", o_waddr, 6);
    chk("mis_wdata", o_wdata, 'hFFFF8123);
    chk("mis_err", o_err, 1);

    // Empty-FIFO response is sticky; then reset in the middle of two pending loads.
    do_reset();
    chk("unf_err_pre", o_err, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 'h5);
    chk("unf_write", o_write, 0);
    chk("unf_err", o_err, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("unf_err_sticky", o_err, 1);
    step(0, 0, 0, 1, 20, 3'b010, 0, 0, 0);
    i_q_rs1 = 5'd20; i_q_rs2 = 5'd21;
    step(1, 5, 'h77, 1, 21, 3'b010, 0, 0, 0);
    chk("mid_pre_write", o_write, 1);
    chk("mid_pre_busy1", o_busy_rs1, 1);
    chk("mid_pre_busy2", o_busy_rs2, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_write", o_write, 0);
    chk("mid_waddr", o_waddr, 0);
    chk("mid_wdata", o_wdata, 0);
    chk("mid_err", o_err, 0);
    chk("mid_ld_ready", o_ld_ready, 1);
    chk("mid_busy1", o_busy_rs1, 0);
    chk("mid_busy2", o_busy_rs2, 0);
    @(negedge clk) i_rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 1, 'hCAFE);
    chk("late_resp_write", o_write, 0);
    chk("late_resp_err", o_err, 1);

    // Random legal traffic against the queue model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [2:0] f3;
      logic [1:0] off;
      off = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: f3 = 3'd0;
        1: f3 = 3'd4;
        2: begin f3 = 3'd1; off[0] = 1'b0; end
        3: begin f3 = 3'd5; off[0] = 1'b0; end
        default: begin f3 = 3'd2; off = 2'd0; end
      endcase
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
             (mq.size() < LD_DEPTH) && ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), f3, off,
             (mq.size() != 0) && ($urandom_range(0, 2) == 0), $urandom);
      i_q_rs1 = 5'($urandom_range(0, 3));
      i_q_rs2 = 5'($urandom_range(0, 3));
      rnd_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
